// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select for the IF/D arbiter: D priority with a starvation bound,
// or alternating round-robin when MEM_ARB_RR_EN is defined.
module mem_arb_grant
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_if_req,
  input  logic   i_d_req,
  output owner_t o_winner
);

  owner_t w_both_pick;

`ifdef MEM_ARB_RR_EN
  owner_t r_last;

  always_ff @(posedge i_clk) begin
    if (i_rst)                  r_last <= OWN_IF;
    else if (o_winner != OWN_NONE) r_last <= o_winner;
  end

  always_comb begin
    w_both_pick = (r_last == OWN_D) ? OWN_IF : OWN_D;
  end
`else
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] r_streak;

  // Counts D grants taken while IF was kept waiting; saturates at the bound.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_streak <= '0;
    else if (!i_if_req || o_winner == OWN_IF)
      r_streak <= '0;
    else if (o_winner == OWN_D && r_streak != STREAK_MAX)
      r_streak <= r_streak + 1'b1;
  end

  always_comb begin
    w_both_pick = (r_streak == STREAK_MAX) ? OWN_IF : OWN_D;
  end
`endif

  always_comb begin
    o_winner = OWN_NONE;
    if (!i_rst) begin
      if (i_if_req && i_d_req) o_winner = w_both_pick;
      else if (i_if_req)       o_winner = OWN_IF;
      else if (i_d_req)        o_winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data access.
// Build option: MEM_ARB_RR_EN selects round-robin instead of bounded D priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  owner_t w_winner;
  owner_t r_owner;
  logic   r_rd;

  mem_arb_grant #(
    .MAX_STREAK(MAX_STREAK)
  ) u_grant (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_if_req (if_req),
    .i_d_req  (d_req),
    .o_winner (w_winner)
  );

  always_comb begin
    if_gnt    = (w_winner == OWN_IF);
    d_gnt     = (w_winner == OWN_D);
    stall     = if_req & ~if_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    case (w_winner)
      OWN_IF: mem_addr = if_addr;
      OWN_D: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_we    = d_we;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
      r_rd    <= 1'b0;
    end else begin
      r_owner <= w_winner;
      r_rd    <= (w_winner == OWN_IF) || (w_winner == OWN_D && !d_we);
    end
  end

  // rst also masks rvalid combinationally so a read granted just before
  // reset never reports in the reset cycle itself.
  always_comb begin
    if_rvalid = !rst && (r_owner == OWN_IF);
    d_rvalid  = !rst && (r_owner == OWN_D) && r_rd;
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios plus randomized traffic.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int MAXS = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, stall;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MAX_STREAK(MAXS)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .stall(stall)
  );

  function automatic logic [15:0] init_val(input logic [15:0] a);
    if (a == 16'h0004) return 16'hA5A5;
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Write-first synchronous memory standing in for the unified Mem.
  logic [15:0] tbmem [64];
  bit          tbwr  [64];
  always @(posedge clk) begin
    if (mem_we) begin
      tbmem[mem_addr[5:0]] <= mem_wdata;
      tbwr[mem_addr[5:0]]  <= 1'b1;
    end
    mem_rdata <= mem_we ? mem_wdata
               : (tbwr[mem_addr[5:0]] ? tbmem[mem_addr[5:0]] : init_val(mem_addr));
  end

  // Reference memory contents as seen by the requesters.
  logic [15:0] mdl [logic [15:0]];
  function automatic logic [15:0] mrd(input logic [15:0] a);
    return mdl.exists(a) ? mdl[a] : init_val(a);
  endfunction

  typedef struct { int due; logic [15:0] data; } exp_t;
  exp_t ifq[$];
  exp_t dq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every rvalid must match the oldest expected read due this cycle.
  always @(negedge clk) begin
    if (if_rvalid) begin
      if (ifq.size() == 0 || ifq[0].due != cyc) chk("if_rvalid_spurious", 1, 0);
      else begin
        chk("if_rdata", if_rdata, ifq[0].data);
        void'(ifq.pop_front());
      end
      chk("d_rdata_nonowner", d_rdata, 0);
    end else if (ifq.size() > 0 && ifq[0].due <= cyc) begin
      chk("if_rvalid_missing", 0, 1);
      void'(ifq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0 || dq[0].due != cyc) chk("d_rvalid_spurious", 1, 0);
      else begin
        chk("d_rdata", d_rdata, dq[0].data);
        void'(dq.pop_front());
      end
      chk("if_rdata_nonowner", if_rdata, 0);
    end else if (dq.size() > 0 && dq[0].due <= cyc) begin
      chk("d_rvalid_missing", 0, 1);
      void'(dq.pop_front());
    end
  end

  // Reference arbitration state: D grants in a row while IF waits / last winner.
  int     d_run = 0;
  owner_t last  = OWN_IF;
  bit     g_if, g_d;

  task automatic cycle(input logic r, input logic ir, input logic [15:0] ia,
                       input logic dr, input logic dw, input logic [15:0] da,
                       input logic [15:0] dwd);
    owner_t ex;
    @(posedge clk);
    #1;
    rst = r; if_req = ir; if_addr = ia;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    if (r) begin
      ifq.delete();
      dq.delete();
    end
    @(negedge clk);
    ex = OWN_NONE;
    if (!r) begin
      if (ir && dr) begin
`ifdef MEM_ARB_RR_EN
        ex = (last == OWN_D) ? OWN_IF : OWN_D;
`else
        ex = (d_run >= MAXS) ? OWN_IF : OWN_D;
`endif
      end else if (ir) ex = OWN_IF;
      else if (dr)     ex = OWN_D;
    end
    chk("if_gnt", if_gnt, ex == OWN_IF);
    chk("d_gnt",  d_gnt,  ex == OWN_D);
    chk("stall",  stall,  ir && ex != OWN_IF);
    chk("mem_we", mem_we, ex == OWN_D && dw);
    chk("mem_addr", mem_addr, ex == OWN_IF ? ia : (ex == OWN_D ? da : 16'h0));
    if (r) begin
      chk("mem_wdata_rst", mem_wdata, 0);
      chk("if_rvalid_rst", if_rvalid, 0);
      chk("d_rvalid_rst",  d_rvalid,  0);
    end else if (ex == OWN_D && dw) chk("mem_wdata", mem_wdata, dwd);
    if (ex == OWN_IF) ifq.push_back('{cyc + 1, mrd(ia)});
    if (ex == OWN_D) begin
      if (dw) mdl[da] = dwd;
      else    dq.push_back('{cyc + 1, mrd(da)});
    end
    if (r) begin
      d_run = 0;
      last  = OWN_IF;
    end else begin
      if (ex == OWN_D && ir) d_run = (d_run < MAXS) ? d_run + 1 : MAXS;
      else                   d_run = 0;
      if (ex != OWN_NONE) last = ex;
    end
    g_if = (ex == OWN_IF);
    g_d  = (ex == OWN_D);
  endtask

  initial begin
    string       pat;
    logic        ir, dr, dw;
    logic [15:0] ia, da, dwd;
    logic [7:0]  pch;
    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset with both requesting, then release: D first, then the held fetch.
    cycle(1, 1, 16'h0004, 1, 0, 16'h0020, 16'h0);
    cycle(1, 1, 16'h0004, 1, 0, 16'h0020, 16'h0);
    cycle(0, 1, 16'h0004, 1, 0, 16'h0020, 16'h0);
    chk("first_after_reset_d_gnt", d_gnt, 1);
    cycle(0, 1, 16'h0004, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);

    // Store, load-back, store-then-fetch of the same word.
    cycle(0, 0, 16'h0000, 1, 1, 16'h0010, 16'h1234);
    cycle(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0);
    cycle(0, 0, 16'h0000, 1, 1, 16'h0006, 16'hBEEF);
    cycle(0, 1, 16'h0006, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);

    // Continuous contention from a clean reset.
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
`ifdef MEM_ARB_RR_EN
    pat = "DIDIDIDI";
`else
    pat = "DDDIDDDI";
`endif
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 16'h0008, 1, 0, 16'(16'h0018 + i), 16'h0);
      pch = pat[i];
      chk("contention_pattern", {g_if, g_d}, (pch == "I") ? 2'b10 : 2'b01);
    end
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);

    // Load granted, reset in the following cycle: its rvalid must not appear.
    cycle(0, 0, 16'h0000, 1, 0, 16'h0010, 16'h0);
    cycle(1, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);

    // Randomized traffic honouring the hold-until-grant rule.
    ir = 0; dr = 0; dw = 0; ia = '0; da = '0; dwd = '0;
    for (int n = 0; n < 500; n++) begin
      if (!(ir && !g_if) || $urandom_range(0, 9) == 0) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 16'($urandom_range(0, 31));
      end
      if (!(dr && !g_d) || $urandom_range(0, 9) == 0) begin
        dr  = ($urandom_range(0, 2) != 0);
        dw  = ($urandom_range(0, 2) == 0);
        da  = 16'($urandom_range(0, 31));
        dwd = 16'($urandom);
      end
      cycle(($urandom_range(0, 49) == 0), ir, ia, dr, dw, da, dwd);
    end
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    cycle(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0);
    chk("ifq_drained", ifq.size(), 0);
    chk("dq_drained",  dq.size(),  0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
